// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-port DataMemory between requester A (CPU load/store
//   stage) and requester B (debug/DMA loader). Round-robin arbitration with
//   one transaction in flight: IDLE accepts, ACCESS drives the memory for
//   exactly one cycle, RESP pulses the owner's response.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     a*/b* request side       Valid/Ready handshake plus Addr, Din,
//                              Write, Size, Sign
//     a*/b* response side      RespValid pulse with Rdata and Err
//     mem*                     DataMemory interface (combinational read)
module data_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              aValid,
   output logic              aReady,
   input  logic [ADDR_W-1:0] aAddr,
   input  logic [DATA_W-1:0] aDin,
   input  logic              aWrite,
   input  logic [1:0]        aSize,
   input  logic              aSign,
   output logic              aRespValid,
   output logic [DATA_W-1:0] aRdata,
   output logic              aErr,
   input  logic              bValid,
   output logic              bReady,
   input  logic [ADDR_W-1:0] bAddr,
   input  logic [DATA_W-1:0] bDin,
   input  logic              bWrite,
   input  logic [1:0]        bSize,
   input  logic              bSign,
   output logic              bRespValid,
   output logic [DATA_W-1:0] bRdata,
   output logic              bErr,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memDin,
   output logic              memWrite,
   output logic              memRead,
   output logic [1:0]        memSize,
   output logic              memSign,
   input  logic [DATA_W-1:0] memDout,
   input  logic              memException
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] din;
      logic              write;
      logic [1:0]        size;
      logic              sign;
      logic              owner;   // 0 = A, 1 = B
   } req_t;

   state_t            state;
   req_t              req;
   req_t              a_req, b_req;
   logic              last_grant; // 0 = A, 1 = B
   logic              grant_b;
   logic              in_access;
   logic              aligned;
   logic              ok;
   logic [DATA_W-1:0] rdata_d;
   logic              err_d;

   assign a_req = '{addr: aAddr, din: aDin, write: aWrite, size: aSize,
                    sign: aSign, owner: 1'b0};
   assign b_req = '{addr: bAddr, din: bDin, write: bWrite, size: bSize,
                    sign: bSign, owner: 1'b1};

   // B wins when it is alone, or on a tie when A was served last.
   assign grant_b = bValid && (!aValid || !last_grant);
   assign aReady  = (state == IDLE) && aValid && !grant_b;
   assign bReady  = (state == IDLE) && grant_b;

   always_comb begin
      aligned = 1'b0;
      case (req.size)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = !req.addr[0];
         2'b10:   aligned = (req.addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   // Memory sees nothing outside the single ACCESS cycle. A misaligned
   // store never writes, and a reset landing on ACCESS kills the write.
   assign in_access = (state == ACCESS);
   assign memAddr   = in_access ? req.addr : '0;
   assign memDin    = in_access ? req.din  : '0;
   assign memSize   = in_access ? req.size : 2'b00;
   assign memSign   = in_access ? req.sign : 1'b0;
   assign memRead   = in_access && !req.write;
   assign memWrite  = in_access && req.write && aligned && !rst;

   assign ok      = aligned && !memException;
   assign rdata_d = (!req.write && ok) ? memDout : '0;
   assign err_d   = !aligned || memException;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         req        <= '0;
         aRespValid <= 1'b0;
         bRespValid <= 1'b0;
         aRdata     <= '0;
         bRdata     <= '0;
         aErr       <= 1'b0;
         bErr       <= 1'b0;
      end else begin
         // Response registers only carry data during the RESP pulse.
         aRespValid <= 1'b0;
         bRespValid <= 1'b0;
         aRdata     <= '0;
         bRdata     <= '0;
         aErr       <= 1'b0;
         bErr       <= 1'b0;
         case (state)
            IDLE: begin
               if (aReady || bReady) begin
                  req   <= grant_b ? b_req : a_req;
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               if (req.owner) begin
                  bRespValid <= 1'b1;
                  bRdata     <= rdata_d;
                  bErr       <= err_d;
               end else begin
                  aRespValid <= 1'b1;
                  aRdata     <= rdata_d;
                  aErr       <= err_d;
               end
               state <= RESP;
            end
            RESP: begin
               last_grant <= req.owner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
